// File: rtl/fabric_config_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : fabric_config_loader_if
// Purpose : Bitstream word stream (valid/ready) into the configuration loader.
// Rev     : 1.0
// ============================================================================
interface fabric_config_loader_if #(
   parameter int FRAME_BITS = 32
);
   logic [FRAME_BITS-1:0] cfg_data_i;
   logic                  cfg_valid_i;
   logic                  cfg_ready_o;

   modport master (output cfg_data_i, output cfg_valid_i, input  cfg_ready_o);
   modport slave  (input  cfg_data_i, input  cfg_valid_i, output cfg_ready_o);
endinterface
`default_nettype wire

// File: rtl/fabric_config_loader.sv
`default_nettype none
// ============================================================================
// Module  : fabric_config_loader
// Purpose : Decodes sync/address/data words into frame data, one-hot frame
//           strobes and row selects; optional checksum via FABRIC_CFG_CHECKSUM_EN.
// Rev     : 1.0
// ============================================================================
module fabric_config_loader #(
   parameter int FRAME_BITS    = 32,
   parameter int MAX_FRAMES    = 20,
   parameter int NUM_ROWS      = 16,
   parameter int STROBE_CYCLES = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   fabric_config_loader_if.slave cfg,
   output logic [FRAME_BITS-1:0] frame_data_o,
   output logic [MAX_FRAMES-1:0] frame_strobe_o,
   output logic [NUM_ROWS-1:0]   row_select_o,
   output logic                  config_active_o,
   output logic                  config_done_o,
   output logic                  config_error_o,
   output logic [15:0]           frames_written_o
);

   localparam logic [FRAME_BITS-1:0] c_SYNC      = FRAME_BITS'(32'hFAB0_FAB1);
   localparam logic [FRAME_BITS-1:0] c_DESYNC    = FRAME_BITS'(32'hFAB0_FAB0);
   localparam logic [8:0]            c_FRAME_LIM = 9'(MAX_FRAMES);
   localparam logic [8:0]            c_ROW_LIM   = 9'(NUM_ROWS);
   localparam int                    c_CNT_W     = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
   localparam logic [c_CNT_W-1:0]    c_CNT_LAST  = c_CNT_W'(STROBE_CYCLES - 1);
   localparam logic [MAX_FRAMES-1:0] c_STRB_ONE  = {{(MAX_FRAMES-1){1'b0}}, 1'b1};
   localparam logic [NUM_ROWS-1:0]   c_ROW_ONE   = {{(NUM_ROWS-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ADDR   = 3'd1,
      S_DATA   = 3'd2,
      S_SETUP  = 3'd3,
      S_STROBE = 3'd4,
      S_HOLD   = 3'd5
`ifdef FABRIC_CFG_CHECKSUM_EN
      , S_CHECK = 3'd6
`endif
   } state_t;

   state_t                  state_q, state_d;
   logic [7:0]              frame_q, frame_d;
   logic [7:0]              row_q, row_d;
   logic [c_CNT_W-1:0]      cnt_q, cnt_d;
   logic [FRAME_BITS-1:0]   data_q, data_d;
   logic [MAX_FRAMES-1:0]   strobe_q, strobe_d;
   logic [NUM_ROWS-1:0]     rowsel_q, rowsel_d;
   logic                    ready_q, ready_d;
   logic                    active_q, active_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;
   logic [15:0]             count_q, count_d;
`ifdef FABRIC_CFG_CHECKSUM_EN
   logic [FRAME_BITS-1:0]   acc_q, acc_d;
`endif

   logic                    w_accept;
   logic [FRAME_BITS-1:0]   w_word;
   logic                    w_addr_bad;

   assign w_word     = cfg.cfg_data_i;
   assign w_accept   = cfg.cfg_valid_i & ready_q;
   assign w_addr_bad = (w_word[FRAME_BITS-1:16] != '0)
                     || ({1'b0, w_word[7:0]}  >= c_FRAME_LIM)
                     || ({1'b0, w_word[15:8]} >= c_ROW_LIM);

   always_comb begin
      state_d  = state_q;
      frame_d  = frame_q;
      row_d    = row_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      rowsel_d = rowsel_q;
      done_d   = 1'b0;
      error_d  = error_q;
      count_d  = count_q;
`ifdef FABRIC_CFG_CHECKSUM_EN
      acc_d    = acc_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (w_accept && (w_word == c_SYNC)) begin
               state_d = S_ADDR;
               error_d = 1'b0;
               count_d = 16'd0;
`ifdef FABRIC_CFG_CHECKSUM_EN
               acc_d   = '0;
`endif
            end
         end
         S_ADDR: begin
            if (w_accept) begin
               if (w_word == c_DESYNC) begin
`ifdef FABRIC_CFG_CHECKSUM_EN
                  state_d = S_CHECK;
`else
                  state_d = S_IDLE;
                  done_d  = 1'b1;
`endif
               end else if (w_word != c_SYNC) begin
                  if (w_addr_bad) begin
                     state_d = S_IDLE;
                     error_d = 1'b1;
                  end else begin
                     frame_d = w_word[7:0];
                     row_d   = w_word[15:8];
                     state_d = S_DATA;
                  end
               end
            end
         end
         S_DATA: begin
            if (w_accept) begin
               data_d   = w_word;
               rowsel_d = c_ROW_ONE << row_q;
               cnt_d    = '0;
               state_d  = S_SETUP;
`ifdef FABRIC_CFG_CHECKSUM_EN
               acc_d    = acc_q ^ w_word;
`endif
            end
         end
         S_SETUP:  state_d = S_STROBE;
         S_STROBE: begin
            if (cnt_q == c_CNT_LAST) state_d = S_HOLD;
            else                     cnt_d   = cnt_q + 1'b1;
         end
         S_HOLD: begin
            state_d = S_ADDR;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
         end
`ifdef FABRIC_CFG_CHECKSUM_EN
         S_CHECK: begin
            if (w_accept) begin
               state_d = S_IDLE;
               if (w_word == acc_q) done_d  = 1'b1;
               else                 error_d = 1'b1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so they track state_q exactly.
      if (state_d == S_IDLE) begin
         data_d   = '0;
         rowsel_d = '0;
      end
      ready_d  = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA)
`ifdef FABRIC_CFG_CHECKSUM_EN
               || (state_d == S_CHECK)
`endif
               ;
      strobe_d = (state_d == S_STROBE) ? (c_STRB_ONE << frame_q) : '0;
      active_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         frame_q  <= '0;
         row_q    <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         strobe_q <= '0;
         rowsel_q <= '0;
         ready_q  <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         count_q  <= 16'd0;
`ifdef FABRIC_CFG_CHECKSUM_EN
         acc_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         frame_q  <= frame_d;
         row_q    <= row_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         strobe_q <= strobe_d;
         rowsel_q <= rowsel_d;
         ready_q  <= ready_d;
         active_q <= active_d;
         done_q   <= done_d;
         error_q  <= error_d;
         count_q  <= count_d;
`ifdef FABRIC_CFG_CHECKSUM_EN
         acc_q    <= acc_d;
`endif
      end
   end

   assign cfg.cfg_ready_o    = ready_q;
   assign frame_data_o       = data_q;
   assign frame_strobe_o     = strobe_q;
   assign row_select_o       = rowsel_q;
   assign config_active_o    = active_q;
   assign config_done_o      = done_q;
   assign config_error_o     = error_q;
   assign frames_written_o   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fabric_config_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_fabric_config_loader
// Purpose : Directed and random stimulus compared each cycle with a
//           transaction-level model of the loader (honours FABRIC_CFG_CHECKSUM_EN).
// Rev     : 1.0
// ============================================================================
module tb_fabric_config_loader;
   localparam int          SC     = 2;
   localparam int          MF     = 20;
   localparam int          NR     = 16;
   localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
   localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   fabric_config_loader_if #(.FRAME_BITS(32)) cfg ();

   logic [31:0]   w_data;
   logic [MF-1:0] w_strobe;
   logic [NR-1:0] w_rowsel;
   logic          w_active, w_done, w_error;
   logic [15:0]   w_count;

   fabric_config_loader #(
      .FRAME_BITS(32), .MAX_FRAMES(MF), .NUM_ROWS(NR), .STROBE_CYCLES(SC)
   ) dut (
      .CLK(CLK), .RST(RST), .cfg(cfg),
      .frame_data_o(w_data), .frame_strobe_o(w_strobe), .row_select_o(w_rowsel),
      .config_active_o(w_active), .config_done_o(w_done), .config_error_o(w_error),
      .frames_written_o(w_count)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   bit chk_en      = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Model: session flags plus "cycles since the last data word was taken".
   bit          m_sess, m_chk, m_addr, m_done, m_err;
   int          m_since = -1;
   logic [7:0]  m_frame, m_row;
   logic [31:0] m_data, m_acc;
   logic [NR-1:0] m_rows;
   logic [15:0] m_cnt;

   task automatic model_reset();
      m_sess = 0; m_chk = 0; m_addr = 0; m_done = 0; m_err = 0; m_since = -1;
      m_frame = '0; m_row = '0; m_data = '0; m_acc = '0; m_rows = '0; m_cnt = '0;
   endtask

   task automatic end_session();
      m_sess = 0; m_chk = 0; m_addr = 0; m_data = '0; m_rows = '0;
   endtask

   function automatic logic [MF-1:0] exp_strobe();
      return (m_since >= 1 && m_since <= SC) ? ({{(MF-1){1'b0}}, 1'b1} << m_frame) : '0;
   endfunction

   initial model_reset();

   always @(posedge CLK) begin
      logic [31:0] w;
      bit          acc;
      cyc++;
      w   = cfg.cfg_data_i;
      acc = (cfg.cfg_valid_i === 1'b1) && (m_since < 0);
      if (RST) model_reset();
      else begin
         m_done = 0;
         if (m_since >= 0) begin
            m_since++;
            if (m_since == SC + 2) begin
               m_since = -1;
               if (m_cnt != 16'hFFFF) m_cnt++;
            end
         end
         if (acc) begin
            if (!m_sess) begin
               if (w == SYNC) begin
                  m_sess = 1; m_err = 0; m_cnt = '0; m_acc = '0; m_addr = 0; m_chk = 0;
               end
            end else if (m_chk) begin
               end_session();
               if (w == m_acc) m_done = 1; else m_err = 1;
            end else if (!m_addr) begin
               if (w == DESYNC) begin
`ifdef FABRIC_CFG_CHECKSUM_EN
                  m_chk = 1;
`else
                  end_session();
                  m_done = 1;
`endif
               end else if (w != SYNC) begin
                  if (w[31:16] != 0 || int'(w[7:0]) >= MF || int'(w[15:8]) >= NR) begin
                     end_session();
                     m_err = 1;
                  end else begin
                     m_addr = 1; m_frame = w[7:0]; m_row = w[15:8];
                  end
               end
            end else begin
               m_data  = w;
               m_rows  = {{(NR-1){1'b0}}, 1'b1} << m_row;
               m_acc   = m_acc ^ w;
               m_addr  = 0;
               m_since = 0;
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("ready",  64'(cfg.cfg_ready_o), 64'(m_since < 0));
         chk("data",   64'(w_data),   64'(m_data));
         chk("strobe", 64'(w_strobe), 64'(exp_strobe()));
         chk("rowsel", 64'(w_rowsel), 64'(m_rows));
         chk("active", 64'(w_active), 64'(m_sess));
         chk("done",   64'(w_done),   64'(m_done));
         chk("error",  64'(w_error),  64'(m_err));
         chk("count",  64'(w_count),  64'(m_cnt));
      end
   end

   logic [MF-1:0] prev_strobe = '0;
   int            rises[$];
   int            done_seen = 0;
   always @(negedge CLK) begin
      if (w_strobe != '0 && prev_strobe == '0) rises.push_back(cyc);
      if (w_done === 1'b1) done_seen++;
      prev_strobe = w_strobe;
   end

   task automatic tick();
      @(negedge CLK);
      cfg.cfg_valid_i = 1'b0;
   endtask

   task automatic send(input logic [31:0] w, input int gap);
      int t;
      for (int i = 0; i < gap; i++) tick();
      @(negedge CLK);
      cfg.cfg_valid_i = 1'b1;
      cfg.cfg_data_i  = w;
      t = 0;
      while (cfg.cfg_ready_o !== 1'b1 && t < 64) begin
         @(negedge CLK);
         t++;
      end
      chk("send_timeout", 64'(t >= 64), 64'(0));
      @(posedge CLK);
   endtask

   function automatic int rgap();
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
   endfunction

   function automatic logic [31:0] good_addr();
      logic [31:0] a;
      a = '0;
      a[7:0]  = 8'($urandom_range(0, MF - 1));
      a[15:8] = 8'($urandom_range(0, NR - 1));
      return a;
   endfunction

   function automatic logic [31:0] bad_addr();
      logic [31:0] a;
      a = good_addr();
      case ($urandom_range(0, 2))
         0:       a[7:0]   = 8'($urandom_range(MF, 255));
         1:       a[15:8]  = 8'($urandom_range(NR, 255));
         default: a[31:16] = 16'($urandom_range(1, 16'hFFFF));
      endcase
      return a;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog cycle %0d: got timeout expected finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      cfg.cfg_valid_i = 1'b0;
      cfg.cfg_data_i  = '0;
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      chk_en = 1'b1;
      @(negedge CLK);
      chk("rst_ready",  64'(cfg.cfg_ready_o), 64'(1));
      chk("rst_strobe", 64'(w_strobe), 64'(0));
      chk("rst_active", 64'(w_active), 64'(0));
      chk("rst_count",  64'(w_count),  64'(0));
      RST = 1'b0;

      // First frame: address 0x305 -> row 3, frame 5.
      send(SYNC, 0);
      send(32'h0000_0305, 0);
      send(32'hDEAD_BEEF, 0);
      tick();
      chk("f1_data",   64'(w_data),   64'(32'hDEAD_BEEF));
      chk("f1_rowsel", 64'(w_rowsel), 64'(16'h0008));
      chk("f1_setup",  64'(w_strobe), 64'(0));
      tick();
      chk("f1_strb1",  64'(w_strobe), 64'(20'h00020));
      chk("model_strb", 64'(exp_strobe()), 64'(20'h00020));
      tick();
      chk("f1_strb2",  64'(w_strobe), 64'(20'h00020));
      tick();
      chk("f1_hold",   64'(w_strobe), 64'(0));
      chk("f1_hdata",  64'(w_data),   64'(32'hDEAD_BEEF));
      tick();
      chk("f1_ready",  64'(cfg.cfg_ready_o), 64'(1));
      chk("f1_count",  64'(w_count), 64'(1));
      chk("model_cnt", 64'(m_cnt),   64'(1));

      send(32'h0000_0014, 0);
      tick();
      chk("bad_error",  64'(w_error),  64'(1));
      chk("bad_active", 64'(w_active), 64'(0));
      chk("bad_strobe", 64'(w_strobe), 64'(0));

      repeat (3) send(32'h1234_5678, 0);
      tick();
      chk("garb_active", 64'(w_active), 64'(0));
      send(SYNC, 0);
      tick();
      chk("sync_active", 64'(w_active), 64'(1));
      chk("sync_error",  64'(w_error),  64'(0));

      // Twenty back-to-back frames with valid held high.
      rises.delete();
      done_seen = 0;
      for (int f = 0; f < 20; f++) begin
         send({16'h0, 8'(f % NR), 8'(f)}, 0);
         send($urandom, 0);
      end
      send(DESYNC, 0);
`ifdef FABRIC_CFG_CHECKSUM_EN
      send(m_acc, 0);
`endif
      repeat (4) tick();
      chk("b2b_strobes", 64'(rises.size()), 64'(20));
      for (int i = 1; i < rises.size(); i++)
         chk("b2b_period", 64'(rises[i] - rises[i-1]), 64'(SC + 4));
      chk("b2b_done",  64'(done_seen), 64'(1));
      chk("b2b_count", 64'(w_count),   64'(20));

      send(SYNC, 0);
      send(32'h0000_0102, 0);
      send(32'hA5A5_5A5A, 0);
      tick();
      tick();
      chk("rs_strobe", 64'(w_strobe), 64'(20'h00004));
      RST = 1'b1;
      @(negedge CLK);
      chk("rs_strobe0", 64'(w_strobe), 64'(0));
      chk("rs_active",  64'(w_active), 64'(0));
      chk("rs_ready",   64'(cfg.cfg_ready_o), 64'(1));
      RST = 1'b0;

`ifdef FABRIC_CFG_CHECKSUM_EN
      for (int k = 0; k < 2; k++) begin
         send(SYNC, 0);
         send(32'h0000_0000, 0);
         send(32'h0F0F_0000, 0);
         send(32'h0000_0001, 0);
         send(32'h0000_0F0F, 0);
         send(DESYNC, 0);
         send((k == 0) ? 32'h0F0F_0F0F : 32'h0, 0);
         tick();
         chk("cs_done",  64'(w_done),  64'(k == 0));
         chk("cs_error", 64'(w_error), 64'(k == 1));
      end
`endif

      for (int s = 0; s < 40; s++) begin
         int nf;
         nf = $urandom_range(0, 6);
         if ($urandom_range(0, 3) == 0) send($urandom & 32'h7FFF_FFFF, rgap());
         send(SYNC, rgap());
         for (int f = 0; f < nf; f++) begin
            int r;
            r = $urandom_range(0, 24);
            if (r == 1) send(SYNC, rgap());
            send((r == 0) ? bad_addr() : good_addr(), rgap());
            send($urandom, rgap());
            if (r == 2) begin
               tick();
               tick();
               RST = 1'b1;
               tick();
               RST = 1'b0;
            end
         end
         send(DESYNC, rgap());
`ifdef FABRIC_CFG_CHECKSUM_EN
         send(($urandom_range(0, 1) == 1) ? m_acc : ~m_acc, rgap());
`endif
         tick();
      end

      repeat (8) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
